aes_decipher: RTL
=================

AES_DECIPHER -- requirements
Module: aes_decipher

Interface
REQ-001 Parameters: none; key length selected at run time by round_num.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 next  in  1  start request; a block is accepted when next & key_ready & state IDLE & legal round_num.
REQ-005 key_ready  in  1  key schedule has all round keys available.
REQ-006 round_num  in  4  Nr: 10 (AES-128), 12 (AES-192) or 14 (AES-256); sampled at accept.
REQ-007 round_key  in  128  key for index `round`, supplied by key schedule; must be stable whenever it is consumed (AddRoundKey cycle).
REQ-008 round  out  4  round-key index currently requested.
REQ-009 cipher  in  128  ciphertext block; sampled at accept; byte 0 = [127:120], column c = bits [127-32c -: 32].
REQ-010 plain  out  128  recovered plaintext, same byte ordering.
REQ-011 plain_valid  out  1  one-cycle pulse when plain is updated.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, INIT, ROUND_LOOP, FINAL_ROUND, DONE.
REQ-014 IDLE -> INIT on accept; cipher and round_num captured; round <= Nr.
REQ-015 INIT (1 cycle): state <= cipher XOR round_key (key Nr); round <= Nr-1; -> ROUND_LOOP.
REQ-016 ROUND_LOOP: 4-cycle sub-counter per round: 0 InvShiftRows, 1 InvSubBytes, 2 AddRoundKey(round_key), 3 InvMixColumns then round <= round-1.
REQ-017 ROUND_LOOP -> FINAL_ROUND at end of sub-step 3 when round was 1 (round becomes 0).
REQ-018 FINAL_ROUND: 3 cycles: InvShiftRows, InvSubBytes, AddRoundKey with key 0; no InvMixColumns; -> DONE.
REQ-019 DONE (1 cycle): plain <= state; plain_valid = 1; -> IDLE.
REQ-020 InvShiftRows: row r rotated right by r byte positions (row 0 unchanged).
REQ-021 InvSubBytes: FIPS-197 inverse S-box on all 16 bytes, combinational within its cycle.
REQ-022 InvMixColumns: per column multiply by {0e,0b,0d,09} in GF(2^8), polynomial 0x11b, completes within one cycle.
REQ-023 Latency: plain_valid visible in the cycle after the 4*Nr-th rising edge following the accept edge (40/48/56 for Nr 10/12/14).
REQ-024 Throughput: one block in flight; next re-accepted no earlier than the cycle after DONE.
REQ-025 next, key_ready, cipher and round_num changes while busy are ignored.
REQ-026 round_num not in {10,12,14}: no accept; block stays IDLE, plain unchanged.
REQ-027 plain holds its value after DONE until the next DONE or reset.
REQ-028 round = 0 in IDLE and DONE.

Reset
REQ-029 On rst: state IDLE, round 0, sub-counter 0, internal state 0, plain 0, plain_valid 0, busy 0.
REQ-030 rst mid-operation aborts the block; no plain_valid is produced for it; next accept possible in the first cycle after rst deasserts.

Verification
REQ-031 AES-128 FIPS-197 C.1: key 000102..0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain 00112233445566778899aabbccddeeff, plain_valid after 40 edges.
REQ-032 AES-192 C.2 key 000102..17, cipher dda97ca4864cdfe06eaf70a0ec0d7191 -> same plain, 48 edges; AES-256 C.3 key 000102..1f, cipher 8ea2b7ca516745bfeafc49904b496089 -> same plain, 56 edges.
REQ-033 round trace for Nr=10: 10,9,...,1,0 in order, each intermediate value held 4 cycles; 0 during FINAL_ROUND.
REQ-034 next pulsed while busy, with cipher changed -> ignored; output matches the first block; no extra plain_valid.
REQ-035 rst asserted at cycle 20 of an AES-128 block -> outputs zeroed, no plain_valid; a new block started immediately after decrypts correctly.
REQ-036 round_num = 11 or key_ready = 0 with next = 1 -> busy stays 0, no plain_valid.

Source files
------------

// File: rtl/aes_decipher.sv
// AES inverse cipher, iterative: one transformation per clock cycle.
// Supports AES-128/192/256; the key length comes from round_num at accept.
// Round keys come from an external schedule indexed by the round output.
module aes_decipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         next,
  input  logic         key_ready,
  input  logic [3:0]   round_num,
  input  logic [127:0] round_key,
  output logic [3:0]   round,
  input  logic [127:0] cipher,
  output logic [127:0] plain,
  output logic         plain_valid,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND_LOOP, FINAL_ROUND, DONE} state_t;

  state_t       st, st_nxt;
  logic [1:0]   sub;
  logic [127:0] blk;
  logic [127:0] cipher_q;
  logic [127:0] step;
  logic         legal_nr;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, matching the S-box definition).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  // Inverse S-box built from its algebraic definition: inverse affine map, then GF inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = s;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  assign legal_nr = (round_num == 4'd10) || (round_num == 4'd12) || (round_num == 4'd14);
  assign accept   = next && key_ready && (st == IDLE) && legal_nr;

  // Select the transformation applied this cycle from the sub-step counter.
  always_comb begin
    step = blk;
    case (sub)
      2'd0:    step = inv_shift_rows(blk);
      2'd1:    step = inv_sub_bytes(blk);
      2'd2:    step = blk ^ round_key;
      default: step = inv_mix_columns(blk);
    endcase
  end

  // Next-state decode and status outputs.
  always_comb begin
    st_nxt      = st;
    busy        = (st != IDLE);
    plain_valid = 1'b0;
    case (st)
      IDLE:        if (accept) st_nxt = INIT;
      INIT:        st_nxt = ROUND_LOOP;
      ROUND_LOOP:  if (sub == 2'd3 && round == 4'd1) st_nxt = FINAL_ROUND;
      FINAL_ROUND: if (sub == 2'd2) st_nxt = DONE;
      DONE: begin
        st_nxt      = IDLE;
        plain_valid = 1'b1;
      end
      default:     st_nxt = IDLE;
    endcase
  end

  // State register, round index, sub-step counter and block datapath.
  // plain is loaded on the final AddRoundKey edge so it is already valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      round    <= 4'd0;
      sub      <= 2'd0;
      blk      <= '0;
      cipher_q <= '0;
      plain    <= '0;
    end else begin
      st <= st_nxt;
      case (st)
        IDLE: begin
          if (accept) begin
            cipher_q <= cipher;
            round    <= round_num;
          end
        end
        INIT: begin
          blk   <= cipher_q ^ round_key;
          round <= round - 4'd1;
        end
        ROUND_LOOP: begin
          blk <= step;
          sub <= sub + 2'd1;
          if (sub == 2'd3) round <= round - 4'd1;
        end
        FINAL_ROUND: begin
          blk <= step;
          if (sub == 2'd2) begin
            sub   <= 2'd0;
            plain <= step;
          end else begin
            sub <= sub + 2'd1;
          end
        end
        default: begin
          sub <= 2'd0;
        end
      endcase
    end
  end

endmodule
